// File: rtl/cc_candy_crush.sv
// rtl/cc_candy_crush.sv - candy-crush scoring engine: 6x6 board, ten swaps, match/stripe/gravity resolve
// Optional macro CC_STRIPE_EN enables striped candies (row/column clears).
module cc_candy_crush (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_1,
  input  logic [2:0] in_color,
  input  logic       in_stripe,
  input  logic [5:0] in_starting_pos,
  input  logic       in_valid_2,
  input  logic [1:0] in_action,
  output logic       out_valid,
  output logic [6:0] out_score
);

  typedef struct packed {
    logic [2:0] color;
    logic       striped;
    logic       orient;
    logic       empty;
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_ACT_BUF, S_SWAP, S_MARK, S_CLEAR_GRAVITY, S_OUT
  } state_t;

  state_t      state, state_nx;
  cell_t       board [36];
  cell_t       grav  [36];
  logic [5:0]  load_cnt, load_idx;
  logic [3:0]  act_cnt;
  logic [5:0]  act_pos [10];
  logic [1:0]  act_dir [10];
  logic [35:0] run_mark, mark_nx, mark_q;
  logic [5:0]  clr_cnt;
  logic [6:0]  score;
  logic [2:0]  a_row, a_col, b_row, b_col, w;
  logic [5:0]  idx_a, idx_b;
  logic        swap_ok;

`ifdef CC_STRIPE_EN
  logic [5:0]  stripe_pos [4];
  logic [3:0]  stripe_ori;
`else
  logic        unused_stripe;
  assign unused_stripe = in_stripe;
`endif

  function automatic logic [5:0] cell_idx(input logic [5:0] p);
    return {3'b000, p[5:3]} * 6'd6 + {3'b000, p[2:0]};
  endfunction

  assign load_idx = (state == S_IDLE) ? 6'd0 : load_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_score = 7'd0;
    case (state)
      S_IDLE:          if (in_valid_1) state_nx = S_LOAD;
      S_LOAD:          if (!in_valid_1) state_nx = S_WAIT;
      S_WAIT:          if (in_valid_2) state_nx = S_ACT_BUF;
      S_ACT_BUF:       if (!in_valid_2) state_nx = S_SWAP;
      S_SWAP:          state_nx = S_MARK;
      S_MARK: begin
        if (|mark_nx)              state_nx = S_CLEAR_GRAVITY;
        else if (act_cnt == 4'd9)  state_nx = S_OUT;
        else                       state_nx = S_SWAP;
      end
      S_CLEAR_GRAVITY: state_nx = S_MARK;
      S_OUT: begin
        state_nx  = S_IDLE;
        out_valid = 1'b1;
        out_score = score;
      end
      default:         state_nx = S_IDLE;
    endcase
  end

  // Neighbour lookup for the current action; off-board cells make the swap a no-op.
  always_comb begin
    a_row   = act_pos[act_cnt][5:3];
    a_col   = act_pos[act_cnt][2:0];
    b_row   = a_row;
    b_col   = a_col;
    swap_ok = (a_row < 3'd6) && (a_col < 3'd6);
    case (act_dir[act_cnt])
      2'd0: begin swap_ok = swap_ok && (a_row != 3'd0); b_row = a_row - 3'd1; end
      2'd1: begin swap_ok = swap_ok && (a_row != 3'd5); b_row = a_row + 3'd1; end
      2'd2: begin swap_ok = swap_ok && (a_col != 3'd0); b_col = a_col - 3'd1; end
      default: begin swap_ok = swap_ok && (a_col != 3'd5); b_col = a_col + 3'd1; end
    endcase
    idx_a = cell_idx({a_row, a_col});
    idx_b = cell_idx({b_row, b_col});
  end

  always_comb begin
    run_mark = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!board[r*6+c].empty && !board[r*6+c+1].empty && !board[r*6+c+2].empty &&
            board[r*6+c].color == board[r*6+c+1].color &&
            board[r*6+c].color == board[r*6+c+2].color) begin
          run_mark[r*6+c]   = 1'b1;
          run_mark[r*6+c+1] = 1'b1;
          run_mark[r*6+c+2] = 1'b1;
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (!board[r*6+c].empty && !board[r*6+c+6].empty && !board[r*6+c+12].empty &&
            board[r*6+c].color == board[r*6+c+6].color &&
            board[r*6+c].color == board[r*6+c+12].color) begin
          run_mark[r*6+c]    = 1'b1;
          run_mark[r*6+c+6]  = 1'b1;
          run_mark[r*6+c+12] = 1'b1;
        end
      end
    end
    mark_nx = run_mark;
`ifdef CC_STRIPE_EN
    // At most four striped cells exist, so four propagation rounds reach closure.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 36; i++) begin
        if (mark_nx[i] && board[i].striped) begin
          if (board[i].orient) begin
            for (int r = 0; r < 6; r++) mark_nx[r*6 + i%6] = 1'b1;
          end else begin
            for (int c = 0; c < 6; c++) mark_nx[(i/6)*6 + c] = 1'b1;
          end
        end
      end
    end
`endif
  end

  always_comb begin
    clr_cnt = '0;
    for (int i = 0; i < 36; i++) begin
      if (mark_q[i] && !board[i].empty) clr_cnt = clr_cnt + 6'd1;
    end
  end

  // Column compaction: surviving cells are packed bottom-up, order preserved.
  always_comb begin
    w = 3'd0;
    for (int i = 0; i < 36; i++) grav[i] = '{color: 3'd0, striped: 1'b0, orient: 1'b0, empty: 1'b1};
    for (int c = 0; c < 6; c++) begin
      w = 3'd5;
      for (int r = 5; r >= 0; r--) begin
        if (!board[r*6+c].empty && !mark_q[r*6+c]) begin
          grav[{3'b000, w} * 6'd6 + 6'(c)] = board[r*6+c];
          w = w - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 36; i++) board[i] <= '0;
      for (int a = 0; a < 10; a++) begin
        act_pos[a] <= '0;
        act_dir[a] <= '0;
      end
      load_cnt <= '0;
      act_cnt  <= '0;
      mark_q   <= '0;
      score    <= '0;
`ifdef CC_STRIPE_EN
      for (int s = 0; s < 4; s++) stripe_pos[s] <= '0;
      stripe_ori <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_valid_1) begin
            if (load_idx < 6'd36)
              board[load_idx] <= '{color: in_color, striped: 1'b0, orient: 1'b0, empty: 1'b0};
`ifdef CC_STRIPE_EN
            if (load_idx < 6'd4) begin
              stripe_pos[load_idx[1:0]] <= in_starting_pos;
              stripe_ori[load_idx[1:0]] <= in_stripe;
            end
`endif
            load_cnt <= load_idx + 6'd1;
            if (state == S_IDLE) score <= '0;
          end else if (state == S_LOAD) begin
            act_cnt <= '0;
`ifdef CC_STRIPE_EN
            // Applied in entry order so a repeated position keeps the last entry.
            for (int s = 0; s < 4; s++) begin
              if (stripe_pos[s][5:3] < 3'd6 && stripe_pos[s][2:0] < 3'd6) begin
                board[cell_idx(stripe_pos[s])].striped <= 1'b1;
                board[cell_idx(stripe_pos[s])].orient  <= stripe_ori[s];
              end
            end
`endif
          end
        end
        S_WAIT, S_ACT_BUF: begin
          if (in_valid_2) begin
            if (act_cnt < 4'd10) begin
              act_pos[act_cnt] <= in_starting_pos;
              act_dir[act_cnt] <= in_action;
              act_cnt          <= act_cnt + 4'd1;
            end
          end else if (state == S_ACT_BUF) begin
            act_cnt <= '0;
          end
        end
        S_SWAP: begin
          if (swap_ok) begin
            board[idx_a] <= board[idx_b];
            board[idx_b] <= board[idx_a];
          end
        end
        S_MARK: begin
          mark_q <= mark_nx;
          if (!(|mark_nx) && act_cnt != 4'd9) act_cnt <= act_cnt + 4'd1;
        end
        S_CLEAR_GRAVITY: begin
          score <= score + {1'b0, clr_cnt};
          for (int i = 0; i < 36; i++) board[i] <= grav[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_candy_crush.sv
// tb/tb_cc_candy_crush.sv - self-checking bench for cc_candy_crush: directed game table plus random games vs model
module tb_cc_candy_crush;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_1;
  logic [2:0] in_color;
  logic       in_stripe;
  logic [5:0] in_starting_pos;
  logic       in_valid_2;
  logic [1:0] in_action;
  logic       out_valid;
  logic [6:0] out_score;

  always #5 clk = ~clk;

  cc_candy_crush dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_1(in_valid_1), .in_color(in_color), .in_stripe(in_stripe),
    .in_starting_pos(in_starting_pos), .in_valid_2(in_valid_2), .in_action(in_action),
    .out_valid(out_valid), .out_score(out_score)
  );

  typedef struct packed {
    logic [35:0][2:0] colors;
    logic [3:0][5:0]  spos;
    logic [3:0]       sori;
    logic [9:0][5:0]  apos;
    logic [9:0][1:0]  adir;
    logic [6:0]       exp_score;
  } game_t;

  int     tests = 0;
  int     fails = 0;
  int     mon_viol = 0;
  logic   prev_valid = 1'b0;
  game_t  tbl [7];
  game_t  g;
  int     got, expv;
  bit     tmo;

`ifdef CC_STRIPE_EN
  localparam bit STRIPES = 1'b1;
`else
  localparam bit STRIPES = 1'b0;
`endif

  always @(negedge clk) begin
    if (out_valid === 1'b0 && out_score !== 7'd0) begin
      mon_viol++;
      $display("FAIL idle_score: out_score=%0d while out_valid=0, required 0", out_score);
    end
    if (out_valid === 1'b1 && prev_valid === 1'b1) begin
      mon_viol++;
      $display("FAIL pulse_width: out_valid high 2 cycles, required 1");
    end
    prev_valid = out_valid;
  end

  task automatic check(input string name, input int actual, input int required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  function automatic game_t base_game();
    game_t b;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) b.colors[r*6+c] = 3'((r + 2*c) % 6);
    for (int s = 0; s < 4; s++) begin b.spos[s] = {3'd0, 3'd5}; b.sori[s] = 1'b0; end
    for (int a = 0; a < 10; a++) begin b.apos[a] = 6'o77; b.adir[a] = 2'd0; end
    b.exp_score = '0;
    return b;
  endfunction

  function automatic game_t single_game();
    game_t b;
    b = base_game();
    b.colors[30] = 3'd1; b.colors[31] = 3'd1; b.colors[32] = 3'd2;
    b.colors[33] = 3'd1; b.colors[34] = 3'd3; b.colors[35] = 3'd4;
    b.apos[0] = {3'd5, 3'd2}; b.adir[0] = 2'd3;
    b.exp_score = 7'd3;
    return b;
  endfunction

  function automatic game_t rand_game(input int pal);
    game_t b;
    for (int k = 0; k < 36; k++) b.colors[k] = 3'($urandom_range(0, pal));
    for (int s = 0; s < 4; s++) begin
      b.spos[s] = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
      b.sori[s] = 1'($urandom_range(0, 1));
    end
    for (int a = 0; a < 10; a++) begin
      b.apos[a] = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
      b.adir[a] = 2'($urandom_range(0, 3));
    end
    b.exp_score = '0;
    return b;
  endfunction

  // Reference: run-length scanning, fixpoint stripe closure, per-column list gravity.
  function automatic int model_score(input game_t gm);
    int colr [6][6];
    bit emp [6][6]; bit str [6][6]; bit ori [6][6]; bit mk [6][6]; bit done [6][6];
    int tc [6]; bit ts [6]; bit tor [6];
    int total, cnt, r0, c0, r1, c1, e, n, t;
    bit any, changed, tb1;
    total = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        colr[r][c] = int'(gm.colors[r*6+c]); emp[r][c] = 0; str[r][c] = 0; ori[r][c] = 0;
      end
    if (STRIPES) begin
      for (int s = 0; s < 4; s++) begin
        r0 = int'(gm.spos[s][5:3]); c0 = int'(gm.spos[s][2:0]);
        if (r0 < 6 && c0 < 6) begin str[r0][c0] = 1; ori[r0][c0] = gm.sori[s]; end
      end
    end
    for (int a = 0; a < 10; a++) begin
      r0 = int'(gm.apos[a][5:3]); c0 = int'(gm.apos[a][2:0]); r1 = r0; c1 = c0;
      case (gm.adir[a])
        2'd0: r1 = r0 - 1;
        2'd1: r1 = r0 + 1;
        2'd2: c1 = c0 - 1;
        default: c1 = c0 + 1;
      endcase
      if (r0 < 6 && c0 < 6 && r1 >= 0 && r1 < 6 && c1 >= 0 && c1 < 6) begin
        t = colr[r0][c0]; colr[r0][c0] = colr[r1][c1]; colr[r1][c1] = t;
        tb1 = emp[r0][c0]; emp[r0][c0] = emp[r1][c1]; emp[r1][c1] = tb1;
        tb1 = str[r0][c0]; str[r0][c0] = str[r1][c1]; str[r1][c1] = tb1;
        tb1 = ori[r0][c0]; ori[r0][c0] = ori[r1][c1]; ori[r1][c1] = tb1;
      end
      while (1) begin
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++) begin mk[r][c] = 0; done[r][c] = 0; end
        for (int r = 0; r < 6; r++) begin
          c0 = 0;
          while (c0 < 6) begin
            e = c0;
            while (e < 5 && !emp[r][c0] && !emp[r][e+1] && colr[r][e+1] == colr[r][c0]) e++;
            if (!emp[r][c0] && e - c0 >= 2) for (int k = c0; k <= e; k++) mk[r][k] = 1;
            c0 = e + 1;
          end
        end
        for (int c = 0; c < 6; c++) begin
          r0 = 0;
          while (r0 < 6) begin
            e = r0;
            while (e < 5 && !emp[r0][c] && !emp[e+1][c] && colr[e+1][c] == colr[r0][c]) e++;
            if (!emp[r0][c] && e - r0 >= 2) for (int k = r0; k <= e; k++) mk[k][c] = 1;
            r0 = e + 1;
          end
        end
        changed = 1;
        while (changed) begin
          changed = 0;
          for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
              if (mk[r][c] && str[r][c] && !done[r][c]) begin
                done[r][c] = 1; changed = 1;
                for (int k = 0; k < 6; k++) begin
                  if (ori[r][c]) mk[k][c] = 1;
                  else mk[r][k] = 1;
                end
              end
        end
        any = 0; cnt = 0;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            if (mk[r][c]) begin
              any = 1;
              if (!emp[r][c]) cnt++;
              emp[r][c] = 1; str[r][c] = 0; ori[r][c] = 0;
            end
        if (!any) break;
        total += cnt;
        for (int c = 0; c < 6; c++) begin
          n = 0;
          for (int r = 5; r >= 0; r--)
            if (!emp[r][c]) begin tc[n] = colr[r][c]; ts[n] = str[r][c]; tor[n] = ori[r][c]; n++; end
          for (int r = 5; r >= 0; r--) begin
            if (5 - r < n) begin
              colr[r][c] = tc[5-r]; emp[r][c] = 0; str[r][c] = ts[5-r]; ori[r][c] = tor[5-r];
            end else begin
              emp[r][c] = 1; str[r][c] = 0; ori[r][c] = 0;
            end
          end
        end
      end
    end
    return total;
  endfunction

  task automatic run_game(input game_t gm, output int score, output bit timed_out);
    score = -1;
    timed_out = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      in_valid_1 = 1'b1;
      in_color   = gm.colors[k];
      if (k < 4) begin
        in_stripe = gm.sori[k]; in_starting_pos = gm.spos[k];
      end else begin
        in_stripe = 1'bx; in_starting_pos = 6'bx;
      end
    end
    @(negedge clk);
    in_valid_1 = 1'b0; in_color = 3'bx; in_stripe = 1'bx; in_starting_pos = 6'bx;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int a = 0; a < 10; a++) begin
      @(negedge clk);
      in_valid_2 = 1'b1; in_starting_pos = gm.apos[a]; in_action = gm.adir[a];
    end
    @(negedge clk);
    in_valid_2 = 1'b0; in_starting_pos = 6'bx; in_action = 2'bx;
    for (int w = 0; w < 500; w++) begin
      if (out_valid === 1'b1) begin
        score = int'(out_score);
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0; in_color = '0;
    in_stripe = 1'b0; in_starting_pos = '0; in_action = '0;
    #2;
    check("reset_valid", int'(out_valid), 0);
    check("reset_score", int'(out_score), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_valid", int'(out_valid), 0);
    check("post_reset_score", int'(out_score), 0);

    tbl[0] = single_game();
    tbl[1] = base_game();
    for (int a = 0; a < 10; a++) begin tbl[1].apos[a] = 6'o00; tbl[1].adir[a] = 2'd0; end
    tbl[2] = single_game();
    tbl[2].apos[0] = {3'd5, 3'd3}; tbl[2].adir[0] = 2'd2;
    tbl[3] = single_game();
    tbl[3].spos[3] = {3'd5, 3'd0}; tbl[3].sori[3] = 1'b0;
    tbl[3].exp_score = STRIPES ? 7'd6 : 7'd3;
    tbl[4] = single_game();
    tbl[4].spos[3] = {3'd5, 3'd0}; tbl[4].sori[3] = 1'b1;
    tbl[4].exp_score = STRIPES ? 7'd8 : 7'd3;
    tbl[5] = single_game();
    tbl[5].spos[2] = {3'd5, 3'd0}; tbl[5].sori[2] = 1'b1;
    tbl[5].spos[3] = {3'd5, 3'd0}; tbl[5].sori[3] = 1'b0;
    tbl[5].exp_score = STRIPES ? 7'd6 : 7'd3;
    tbl[6] = base_game();
    tbl[6].colors[30] = 3'd1; tbl[6].colors[31] = 3'd1; tbl[6].colors[32] = 3'd1;
    tbl[6].colors[33] = 3'd1; tbl[6].colors[34] = 3'd3; tbl[6].colors[35] = 3'd4;
    tbl[6].exp_score = 7'd4;

    for (int i = 0; i < 7; i++) begin
      run_game(tbl[i], got, tmo);
      check($sformatf("tbl%0d_done", i), int'(tmo), 0);
      check($sformatf("tbl%0d_score", i), got, int'(tbl[i].exp_score));
      repeat (2) @(negedge clk);
    end

    run_game(single_game(), got, tmo);
    check("async_game_score", got, 3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_score", int'(out_score), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid_1 = 1'b1; in_color = 3'($urandom_range(0, 5));
      in_stripe = 1'b0; in_starting_pos = 6'o05;
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid_1 = 1'b0;
    #1;
    check("midload_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_game(single_game(), got, tmo);
    check("after_abort_done", int'(tmo), 0);
    check("after_abort_score", got, 3);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      g = rand_game(2 + i % 4);
      expv = model_score(g);
      run_game(g, got, tmo);
      check($sformatf("rand%0d_done", i), int'(tmo), 0);
      check($sformatf("rand%0d_score", i), got, expv);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("protocol", mon_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
